icache_axi_rd_bridge: RTL and testbench

Read-only bus adapter between the instruction cache's memory port and the AXI4 read channels of the system interconnect. It converts each single-word cache refill request (`mem_req` / `mem_addr_ok` / `mem_data_ok`) into one single-beat AXI4 read and tracks up to `MAX_OUTSTANDING` reads in flight. Read data is returned to the cache in order, one registered word per beat. The block has no write channels. The instruction fetch path never writes memory.

---
 rtl/icache_axi_rd_bridge.sv | 132 +++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge
//   Read-only adapter from the iCache word-refill port to AXI4 AR/R.
//   Each accepted request becomes one single-beat INCR read. Up to
//   MAX_OUTSTANDING reads may be in flight. Data returns in order, one
//   registered word per R beat.
//
// Ports
//   clk, reset                  : clock, async active-high reset
//   mem_req / mem_read_addr     : iCache word read request
//   mem_addr_ok                 : request accepted this cycle (combinational)
//   mem_data_ok / mem_read_data : returned word, one-cycle pulse
//   arid..arburst, arvalid/arready : AXI AR channel
//   rid, rdata, rresp, rlast, rvalid / rready : AXI R channel
//   bus_err                     : sticky error (bad rresp, bad rid, unsolicited beat)
module icache_axi_rd_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [3:0]  ARID_VALUE      = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic [31:0] mem_read_addr,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [31:0] mem_read_data,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  localparam int unsigned   CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  typedef enum logic {AR_IDLE, AR_PEND} ar_state_e;

  ar_state_e     state_q, state_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          dok_q, dok_d;
  logic          err_q, err_d;

  logic accept, r_hs, r_ok, dec;

  // Constant AR payload: single 32-bit beat, fixed ID
  assign arid    = ARID_VALUE;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign rready  = 1'b1;

  assign arvalid       = (state_q == AR_PEND);
  assign araddr        = araddr_q;
  assign mem_data_ok   = dok_q;
  assign mem_read_data = rdata_q;
  assign bus_err       = err_q;

  // Accept uses the registered count only, so a same-cycle R beat does not
  // free a slot until the next cycle (keeps rvalid off every output path).
  assign accept      = mem_req && (!arvalid || arready) && (cnt_q < MAX_C);
  assign mem_addr_ok = accept;

  assign r_hs = rvalid;              // rready is always 1
  assign r_ok = r_hs && (cnt_q != '0);
  assign dec  = r_ok && rlast;

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    unique case (state_q)
      AR_IDLE: if (accept) begin
        state_d  = AR_PEND;
        araddr_d = mem_read_addr;
      end
      AR_PEND: if (arready) begin
        // Reload on the handshake cycle for back-to-back issue
        if (accept) araddr_d = mem_read_addr;
        else        state_d  = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, dec})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Beats with nothing outstanding are dropped but flagged
  always_comb begin
    dok_d   = r_ok;
    rdata_d = r_ok ? rdata : rdata_q;
    err_d   = err_q
            | (r_hs && (cnt_q == '0))
            | (r_ok && (rresp != 2'b00))
            | (r_ok && (rid != ARID_VALUE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= AR_IDLE;
      araddr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      dok_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      dok_q    <= dok_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
module tb_icache_axi_rd_bridge;
  localparam int         MAXO = 4;
  localparam logic [3:0] ARID = 4'd0;

  logic clk, reset;
  logic mem_req, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_read_addr, mem_read_data;
  logic [3:0] arid; logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
  logic arvalid, arready;
  logic [3:0] rid; logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic bus_err;

  int n_chk = 0;
  int n_fail = 0;

  icache_axi_rd_bridge #(.MAX_OUTSTANDING(MAXO), .ARID_VALUE(ARID)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_read_addr(mem_read_addr), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_read_data(mem_read_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2408_5A5A;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    mem_req = 0; mem_read_addr = 0; arready = 0;
    rid = ARID; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; #3;
    n_chk++; if (arvalid !== 0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    n_chk++; if (araddr !== 0) begin n_fail++; $display("FAIL rst_araddr: got %h want 0", araddr); end
    n_chk++; if (mem_data_ok !== 0 || mem_read_data !== 0) begin n_fail++; $display("FAIL rst_data: got %b/%h want 0/0", mem_data_ok, mem_read_data); end
    n_chk++; if (bus_err !== 0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus_err); end
    n_chk++; if (int'(dut.cnt_q) != 0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", dut.cnt_q); end
    n_chk++; if (rready !== 1 || arlen !== 0 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== ARID)
      begin n_fail++; $display("FAIL rst_const: got rready=%b arlen=%h arsize=%b arburst=%b arid=%h", rready, arlen, arsize, arburst, arid); end
    tick(); reset = 0;
  endtask

  task automatic test_single();
    do_reset();
    mem_req = 1; mem_read_addr = 32'hBFC0_0000; arready = 1; #2;
    n_chk++; if (mem_addr_ok !== 1) begin n_fail++; $display("FAIL single_acc: got %b want 1", mem_addr_ok); end
    tick(); mem_req = 0;
    n_chk++; if (arvalid !== 1 || araddr !== 32'hBFC0_0000 || arlen !== 0)
      begin n_fail++; $display("FAIL single_ar: got v=%b a=%h len=%h want 1/bfc00000/0", arvalid, araddr, arlen); end
    tick();
    n_chk++; if (arvalid !== 0) begin n_fail++; $display("FAIL single_ar_once: got %b want 0", arvalid); end
    tick();
    rvalid = 1; rdata = 32'h2408_0001; rlast = 1;
    tick(); rvalid = 0;
    n_chk++; if (mem_data_ok !== 1 || mem_read_data !== 32'h2408_0001)
      begin n_fail++; $display("FAIL single_data: got %b/%h want 1/24080001", mem_data_ok, mem_read_data); end
    tick();
    n_chk++; if (mem_data_ok !== 0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", mem_data_ok); end
    n_chk++; if (int'(dut.cnt_q) != 0 || bus_err !== 0) begin n_fail++; $display("FAIL single_end: got cnt=%0d err=%b want 0/0", dut.cnt_q, bus_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    arready = 1;
    for (int i = 0; i < 6; i++) begin
      mem_req = (i < 4);
      mem_read_addr = 32'(32'h1000 + 4 * i);
      rvalid = (i >= 2);
      rdata = hsh(32'(32'h1000 + 4 * (i - 2)));
      #2;
      n_chk++; if (mem_addr_ok !== (i < 4)) begin n_fail++; $display("FAIL b2b_acc[%0d]: got %b want %b", i, mem_addr_ok, (i < 4)); end
      tick();
      if (i < 4) begin
        n_chk++; if (arvalid !== 1 || araddr !== 32'(32'h1000 + 4 * i))
          begin n_fail++; $display("FAIL b2b_ar[%0d]: got %b/%h want 1/%h", i, arvalid, araddr, 32'h1000 + 4 * i); end
      end
      n_chk++; if (mem_data_ok !== (i >= 2)) begin n_fail++; $display("FAIL b2b_dok[%0d]: got %b want %b", i, mem_data_ok, (i >= 2)); end
      if (i >= 2) begin
        n_chk++; if (mem_read_data !== hsh(32'(32'h1000 + 4 * (i - 2))))
          begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, mem_read_data, hsh(32'(32'h1000 + 4 * (i - 2)))); end
      end
    end
    idle_inputs(); tick();
    n_chk++; if (int'(dut.cnt_q) != 0 || arvalid !== 0) begin n_fail++; $display("FAIL b2b_end: got cnt=%0d arvalid=%b want 0/0", dut.cnt_q, arvalid); end
  endtask

  task automatic test_outstanding();
    do_reset();
    arready = 1; mem_req = 1;
    for (int i = 0; i < 6; i++) begin
      mem_read_addr = 32'(32'h2000 + 4 * i); #2;
      n_chk++; if (mem_addr_ok !== (i < MAXO)) begin n_fail++; $display("FAIL lim_acc[%0d]: got %b want %b", i, mem_addr_ok, (i < MAXO)); end
      tick();
    end
    n_chk++; if (int'(dut.cnt_q) != MAXO) begin n_fail++; $display("FAIL lim_cnt_full: got %0d want %0d", dut.cnt_q, MAXO); end
    // The slot freed by an R beat is only visible the following cycle
    rvalid = 1; rdata = 32'h0000_2000; #2;
    n_chk++; if (mem_addr_ok !== 0) begin n_fail++; $display("FAIL lim_acc_on_r: got %b want 0", mem_addr_ok); end
    tick(); rvalid = 0;
    n_chk++; if (int'(dut.cnt_q) != MAXO - 1) begin n_fail++; $display("FAIL lim_cnt_dec: got %0d want %0d", dut.cnt_q, MAXO - 1); end
    #2;
    n_chk++; if (mem_addr_ok !== 1) begin n_fail++; $display("FAIL lim_acc_free: got %b want 1", mem_addr_ok); end
    tick(); mem_req = 0;
    n_chk++; if (int'(dut.cnt_q) != MAXO) begin n_fail++; $display("FAIL lim_cnt_refill: got %0d want %0d", dut.cnt_q, MAXO); end
    rvalid = 1;
    for (int i = 0; i < MAXO; i++) tick();
    rvalid = 0; tick();
    n_chk++; if (int'(dut.cnt_q) != 0 || bus_err !== 0) begin n_fail++; $display("FAIL lim_drain: got cnt=%0d err=%b want 0/0", dut.cnt_q, bus_err); end
  endtask

  task automatic test_ar_backpressure();
    do_reset();
    arready = 0; mem_req = 1; mem_read_addr = 32'h3000; #2;
    n_chk++; if (mem_addr_ok !== 1) begin n_fail++; $display("FAIL bp_first: got %b want 1", mem_addr_ok); end
    tick(); mem_read_addr = 32'h3004;
    for (int k = 0; k < 5; k++) begin
      #2;
      n_chk++; if (mem_addr_ok !== 0 || arvalid !== 1 || araddr !== 32'h3000)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got ok=%b v=%b a=%h want 0/1/3000", k, mem_addr_ok, arvalid, araddr); end
      tick();
    end
    arready = 1; #2;
    n_chk++; if (mem_addr_ok !== 1) begin n_fail++; $display("FAIL bp_rise: got %b want 1", mem_addr_ok); end
    tick(); mem_req = 0;
    n_chk++; if (arvalid !== 1 || araddr !== 32'h3004) begin n_fail++; $display("FAIL bp_second: got %b/%h want 1/3004", arvalid, araddr); end
    tick();
    n_chk++; if (arvalid !== 0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", arvalid); end
    rvalid = 1; tick(); tick(); rvalid = 0; tick();
    n_chk++; if (int'(dut.cnt_q) != 0) begin n_fail++; $display("FAIL bp_cnt: got %0d want 0", dut.cnt_q); end
  endtask

  task automatic test_errors();
    // SLVERR response: data still delivered, error flagged
    do_reset();
    arready = 1; mem_req = 1; mem_read_addr = 32'h4000; tick(); mem_req = 0; tick();
    rvalid = 1; rresp = 2'b10; rdata = 32'hDEAD_0001; tick(); rvalid = 0; rresp = 0;
    n_chk++; if (mem_data_ok !== 1 || mem_read_data !== 32'hDEAD_0001 || bus_err !== 1)
      begin n_fail++; $display("FAIL err_rresp: got %b/%h/%b want 1/dead0001/1", mem_data_ok, mem_read_data, bus_err); end
    // Wrong RID: data still delivered, error flagged
    do_reset();
    arready = 1; mem_req = 1; mem_read_addr = 32'h4004; tick(); mem_req = 0; tick();
    rvalid = 1; rid = ARID ^ 4'h5; rdata = 32'hDEAD_0002; tick(); rvalid = 0; rid = ARID;
    n_chk++; if (mem_data_ok !== 1 || mem_read_data !== 32'hDEAD_0002 || bus_err !== 1)
      begin n_fail++; $display("FAIL err_rid: got %b/%h/%b want 1/dead0002/1", mem_data_ok, mem_read_data, bus_err); end
    // Unsolicited beat: dropped, error flagged, sticky until reset
    do_reset();
    rvalid = 1; rdata = 32'hDEAD_0003; tick(); rvalid = 0;
    n_chk++; if (mem_data_ok !== 0 || bus_err !== 1 || int'(dut.cnt_q) != 0)
      begin n_fail++; $display("FAIL err_unsol: got dok=%b err=%b cnt=%0d want 0/1/0", mem_data_ok, bus_err, dut.cnt_q); end
    repeat (3) tick();
    n_chk++; if (bus_err !== 1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", bus_err); end
    do_reset();
    n_chk++; if (bus_err !== 0) begin n_fail++; $display("FAIL err_clear: got %b want 0", bus_err); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    arready = 1; mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      mem_read_addr = 32'(32'h5000 + 4 * i);
      rvalid = (i == 3); rdata = 32'hCAFE_0003;
      tick();
    end
    mem_req = 0; rvalid = 0;
    n_chk++; if (int'(dut.cnt_q) != 3 || arvalid !== 1 || mem_data_ok !== 1)
      begin n_fail++; $display("FAIL mid_pre: got cnt=%0d v=%b dok=%b want 3/1/1", dut.cnt_q, arvalid, mem_data_ok); end
    #2; reset = 1; #1;
    n_chk++; if (arvalid !== 0 || araddr !== 0 || mem_data_ok !== 0 || mem_read_data !== 0 || bus_err !== 0 || int'(dut.cnt_q) != 0)
      begin n_fail++; $display("FAIL mid_async: got v=%b a=%h dok=%b d=%h err=%b cnt=%0d want all 0", arvalid, araddr, mem_data_ok, mem_read_data, bus_err, dut.cnt_q); end
    #2; reset = 0;
    tick();
    rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (mem_data_ok !== 0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b want 0", i, mem_data_ok); end
    end
    rvalid = 0; tick();
    n_chk++; if (int'(dut.cnt_q) != 0 || bus_err !== 1) begin n_fail++; $display("FAIL mid_end: got cnt=%0d err=%b want 0/1", dut.cnt_q, bus_err); end
  endtask

  // Random traffic against a reference built from transaction queues:
  // requests issued, AR beats delivered to a memory model, words returned.
  task automatic test_random();
    logic [31:0] ar_q[$];   // addresses handed to the slave, awaiting R
    logic [31:0] dat_q[$];  // words the slave has returned, awaiting delivery
    int   inflight;
    bit   pend;
    logic [31:0] pend_addr, tmp;
    bit   exp_acc, sent_r;
    do_reset();
    inflight = 0; pend = 0; pend_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_req = ($urandom_range(0, 2) != 0);
      tmp = $urandom(); mem_read_addr = tmp & 32'hFFFF_FFFC;
      arready = ($urandom_range(0, 3) != 0);
      sent_r = (ar_q.size() > 0) && ($urandom_range(0, 2) != 0);
      rvalid = sent_r;
      rdata = sent_r ? hsh(ar_q[0]) : 32'h0;
      #2;
      exp_acc = mem_req && (!pend || arready) && (inflight < MAXO);
      n_chk++; if (mem_addr_ok !== exp_acc) begin n_fail++; $display("FAIL rnd_acc[%0d]: got %b want %b", c, mem_addr_ok, exp_acc); end
      if (pend && arready) begin ar_q.push_back(pend_addr); pend = 0; end
      if (sent_r) begin dat_q.push_back(hsh(ar_q.pop_front())); inflight--; end
      if (exp_acc) begin inflight++; pend = 1; pend_addr = mem_read_addr; end
      tick();
      n_chk++; if (arvalid !== pend || (pend && araddr !== pend_addr))
        begin n_fail++; $display("FAIL rnd_ar[%0d]: got %b/%h want %b/%h", c, arvalid, araddr, pend, pend_addr); end
      n_chk++; if (mem_data_ok !== sent_r) begin n_fail++; $display("FAIL rnd_dok[%0d]: got %b want %b", c, mem_data_ok, sent_r); end
      if (sent_r) begin
        tmp = dat_q.pop_front();
        n_chk++; if (mem_read_data !== tmp) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", c, mem_read_data, tmp); end
      end
      n_chk++; if (int'(dut.cnt_q) != inflight || bus_err !== 0)
        begin n_fail++; $display("FAIL rnd_state[%0d]: got cnt=%0d err=%b want %0d/0", c, dut.cnt_q, bus_err, inflight); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_outstanding();
    test_ar_backpressure();
    test_errors();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
